// File: rtl/lvdt_phase_ctrl.sv
// Multi-channel LVDT demodulator phase controller: Avalon-MM shadow registers,
// atomic commit to per-channel targets, optional wrap-aware 1-LSB/tick slewing.
module lvdt_phase_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned PRESCALE = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic              read_n,
  output logic [31:0]       readdata,
  output logic [NCH*W-1:0]  out_phase,
  output logic              busy
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [AW-1:0] CTRL_ADDR   = AW'(NCH);
  localparam logic [AW-1:0] STATUS_ADDR = AW'(NCH + 1);
  localparam logic [W-1:0]  HALF        = {1'b1, {(W-1){1'b0}}};
  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);

  logic [W-1:0]   shadow_q [NCH];
  logic [W-1:0]   target_q [NCH];
  logic [W-1:0]   active_q [NCH];
  logic [W-1:0]   active_d [NCH];
  logic [W-1:0]   delta    [NCH];
  logic           ramp_en_q;
  logic [PW-1:0]  presc_q;
  logic           busy_q;
  logic [31:0]    readdata_q;
  logic [31:0]    rdata_d;
  logic [NCH-1:0] diff;
  logic           wr_en;
  logic           rd_en;
  logic           ctrl_wr;
  logic           ramp_eff;
  logic           tick;
  logic           unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign ctrl_wr      = wr_en && (address == CTRL_ADDR);
  // A RAMP_EN write governs the active update on the very edge it is written
  assign ramp_eff     = ctrl_wr ? writedata[1] : ramp_en_q;
  assign tick         = (presc_q == PRESC_LAST);
  assign unused_wdata = ^writedata[31:W];

  always_comb begin
    diff = '0;
    for (int n = 0; n < NCH; n++) begin
      diff[n]  = (active_q[n] != target_q[n]);
      delta[n] = target_q[n] - active_q[n];
    end
  end

  // Next applied phase: snap when ramping is off, else shortest-path 1-LSB step per tick
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      active_d[n] = active_q[n];
      if (!ramp_eff) begin
        active_d[n] = target_q[n];
      end else if (tick && diff[n]) begin
        if (!delta[n][W-1] || (delta[n] == HALF)) begin
          active_d[n] = active_q[n] + W'(1);
        end else begin
          active_d[n] = active_q[n] - W'(1);
        end
      end
    end
  end

  // Read mux
  always_comb begin
    rdata_d = '0;
    for (int n = 0; n < NCH; n++) begin
      if (address == AW'(n)) begin
        rdata_d = 32'(shadow_q[n]);
      end
    end
    if (address == CTRL_ADDR) begin
      rdata_d = {30'b0, ramp_en_q, 1'b0};
    end else if (address == STATUS_ADDR) begin
      rdata_d = 32'({diff, busy_q});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NCH; n++) begin
        shadow_q[n] <= '0;
        target_q[n] <= '0;
        active_q[n] <= '0;
      end
      ramp_en_q  <= 1'b0;
      presc_q    <= '0;
      busy_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (wr_en && (address == AW'(n))) begin
          shadow_q[n] <= writedata[W-1:0];
        end
        if (ctrl_wr && writedata[0]) begin
          target_q[n] <= shadow_q[n];
        end
        active_q[n] <= active_d[n];
      end
      if (ctrl_wr) begin
        ramp_en_q <= writedata[1];
      end
      presc_q <= tick ? '0 : presc_q + PW'(1);
      busy_q  <= |diff;
      if (rd_en) begin
        readdata_q <= rdata_d;
      end
    end
  end

  always_comb begin
    out_phase = '0;
    for (int n = 0; n < NCH; n++) begin
      out_phase[n*W +: W] = active_q[n];
    end
  end

  assign readdata = readdata_q;
  assign busy     = busy_q;

endmodule
